// File: rtl/clint_pkg.sv
// clint_pkg: shared constants for the CLINT timer block.
//   CLINT_MSIP_BASE      byte address of msip[0]; msip[h] sits at +4h
//   CLINT_MTIMECMP_BASE  byte address of mtimecmp[0] low half; mtimecmp[h] sits at +8h
//   CLINT_MTIME_ADDR     byte address of mtime low half; high half at +4
//   MTIMECMP_RST         reset value of every mtimecmp (never reached, so no mtip)
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_ADDR    = 16'hBFF8;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk_free down to the mtime increment rate.
// Ports:
//   clk_free  in   free-running clock
//   rstn      in   asynchronous active-low reset
//   clr       in   restart the division period (mtime was written this cycle)
//   tick      out  high in the last clk_free cycle of each TICK_DIV period
module clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk_free,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  // With TICK_DIV = 1 the counter never leaves 0, so tick is constantly high.
  assign tick = (div_cnt == LAST);

  always_ff @(posedge clk_free or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor timer (mtime, per-hart mtimecmp and msip).
// Ports:
//   clk_free, rstn         clock, asynchronous active-low reset
//   psel, penable, pwrite  APB control
//   paddr[15:0]            APB byte address
//   pwdata[31:0]           APB write data
//   prdata[31:0]           APB read data (combinational, 0 outside the access phase)
//   pready                 tied high, no wait states
//   pslverr                high in the access phase of an unmapped/misaligned access
//   mtime[63:0]            registered timer value
//   mtip[NHART-1:0]        timer interrupt pending per hart
//   msip[NHART-1:0]        software interrupt pending per hart
//
// APB handshake: a transfer is the single cycle with psel & penable high; since
// pready is constantly 1, that cycle always completes. Writes take effect at the
// closing rising edge, read data and pslverr are valid during that same cycle.
// A rejected transfer (pslverr = 1) changes no state.
module clint_timer
  import clint_pkg::*;
#(
  parameter int NHART    = 1,
  parameter int TICK_DIV = 1
) (
  input  logic             clk_free,
  input  logic             rstn,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [15:0]      paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  output logic [63:0]      mtime,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  logic        access;
  logic        aligned;
  logic [15:0] msip_off;
  logic [15:0] cmp_off;
  logic        sel_msip;
  logic        sel_cmp;
  logic        sel_mtime_lo;
  logic        sel_mtime_hi;
  logic        addr_ok;
  logic        wr;
  logic        mtime_wr;
  logic        tick;
  logic [2:0]  msip_h;
  logic [2:0]  cmp_h;
  logic        cmp_hi;

  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_q    [NHART];
  logic [63:0] mtimecmp_next [NHART];

  // Offsets wrap to large values below the region base, so a single
  // upper-bound compare also rejects addresses under the base.
  assign access       = psel & penable;
  assign aligned      = (paddr[1:0] == 2'b00);
  assign msip_off     = paddr - CLINT_MSIP_BASE;
  assign cmp_off      = paddr - CLINT_MTIMECMP_BASE;
  assign sel_msip     = aligned & (msip_off < 16'(4 * NHART));
  assign sel_cmp      = aligned & (cmp_off < 16'(8 * NHART));
  assign sel_mtime_lo = (paddr == CLINT_MTIME_ADDR);
  assign sel_mtime_hi = (paddr == CLINT_MTIME_ADDR + 16'd4);
  assign msip_h       = msip_off[4:2];
  assign cmp_h        = cmp_off[5:3];
  assign cmp_hi       = cmp_off[2];
  assign addr_ok      = sel_msip | sel_cmp | sel_mtime_lo | sel_mtime_hi;

  assign wr       = access & pwrite & addr_ok;
  assign mtime_wr = wr & (sel_mtime_lo | sel_mtime_hi);
  assign pready   = 1'b1;
  assign pslverr  = access & ~addr_ok;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_free (clk_free),
    .rstn     (rstn),
    .clr      (mtime_wr),
    .tick     (tick)
  );

  always_comb begin
    prdata = '0;
    if (access && addr_ok) begin
      for (int h = 0; h < NHART; h++) begin
        if (sel_msip && msip_h == 3'(h)) prdata = {31'b0, msip[h]};
        if (sel_cmp && cmp_h == 3'(h)) begin
          prdata = cmp_hi ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
        end
      end
      if (sel_mtime_lo) prdata = mtime[31:0];
      if (sel_mtime_hi) prdata = mtime[63:32];
    end
  end

  // A software write to either half of mtime wins over the increment.
  always_comb begin
    mtime_next = mtime;
    if (wr && sel_mtime_lo) begin
      mtime_next[31:0] = pwdata;
    end else if (wr && sel_mtime_hi) begin
      mtime_next[63:32] = pwdata;
    end else if (tick) begin
      mtime_next = mtime + 64'd1;
    end
  end

  always_comb begin
    for (int h = 0; h < NHART; h++) begin
      mtimecmp_next[h] = mtimecmp_q[h];
      if (wr && sel_cmp && cmp_h == 3'(h)) begin
        if (cmp_hi) mtimecmp_next[h][63:32] = pwdata;
        else        mtimecmp_next[h][31:0]  = pwdata;
      end
    end
  end

  // mtip compares the post-update values so it lines up with the mtime register.
  always_ff @(posedge clk_free or negedge rstn) begin
    if (!rstn) begin
      mtime <= '0;
      mtip  <= '0;
      msip  <= '0;
      for (int h = 0; h < NHART; h++) mtimecmp_q[h] <= MTIMECMP_RST;
    end else begin
      mtime <= mtime_next;
      for (int h = 0; h < NHART; h++) begin
        mtimecmp_q[h] <= mtimecmp_next[h];
        mtip[h]       <= (mtime_next >= mtimecmp_next[h]);
        if (wr && sel_msip && msip_h == 3'(h)) msip[h] <= pwdata[0];
      end
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
module tb_clint_timer;

  localparam int NH = 2;

  // clock / reset
  logic clk_free = 1'b0;
  logic rstn;
  always #5 clk_free = ~clk_free;

  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [63:0] mtime0, mtime1;
  logic [NH-1:0] mtip0, mtip1, msip0, msip1;

  clint_timer #(.NHART(NH), .TICK_DIV(1)) dut_div1 (
    .clk_free (clk_free), .rstn (rstn), .psel (psel), .penable (penable),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .prdata (prdata0),
    .pready (pready0), .pslverr (pslverr0), .mtime (mtime0), .mtip (mtip0),
    .msip (msip0)
  );

  clint_timer #(.NHART(NH), .TICK_DIV(4)) dut_div4 (
    .clk_free (clk_free), .rstn (rstn), .psel (psel), .penable (penable),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .prdata (prdata1),
    .pready (pready1), .pslverr (pslverr1), .mtime (mtime1), .mtip (mtip1),
    .msip (msip1)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // Reference model: mtime = last written value + (edges since write) / TICK_DIV.
  logic [63:0]   m_anchor [2];
  int unsigned   m_n      [2];
  int unsigned   m_td     [2];
  logic [63:0]   m_cmp    [NH];
  logic [NH-1:0] m_msip;
  logic [NH-1:0] m_mtip   [2];

  function automatic logic [63:0] m_now(int i);
    return m_anchor[i] + 64'(m_n[i] / m_td[i]);
  endfunction

  function automatic bit addr_valid(logic [15:0] a);
    int ai;
    ai = int'(a);
    if (a[1:0] != 2'b00) return 1'b0;
    return (ai < 4 * NH) || (ai >= 'h4000 && ai < 'h4000 + 8 * NH) ||
           (ai == 'hBFF8) || (ai == 'hBFFC);
  endfunction

  function automatic logic [31:0] m_read(int i, logic [15:0] a);
    int ai;
    logic [63:0] t;
    ai = int'(a);
    if (!addr_valid(a)) return 32'h0;
    if (ai < 4 * NH) return {31'b0, m_msip[ai / 4]};
    if (ai == 'hBFF8) begin t = m_now(i); return t[31:0]; end
    if (ai == 'hBFFC) begin t = m_now(i); return t[63:32]; end
    t = m_cmp[(ai - 'h4000) / 8];
    return ((ai % 8) == 4) ? t[63:32] : t[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_anchor[i] = 64'h0;
      m_n[i]      = 0;
      m_mtip[i]   = '0;
    end
    for (int h = 0; h < NH; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_msip = '0;
  endtask

  // Applies the effect of one rising edge, using the bus inputs held across it.
  task automatic model_edge();
    logic [63:0] now;
    int ai, h;
    bit w;
    if (!rstn) return;
    ai = int'(paddr);
    w  = psel && penable && pwrite && addr_valid(paddr);
    for (int i = 0; i < 2; i++) begin
      now = m_now(i);
      if (w && ai == 'hBFF8) begin
        m_anchor[i] = {now[63:32], pwdata}; m_n[i] = 0;
      end else if (w && ai == 'hBFFC) begin
        m_anchor[i] = {pwdata, now[31:0]}; m_n[i] = 0;
      end else begin
        m_n[i]++;
      end
    end
    if (w && ai < 4 * NH) m_msip[ai / 4] = pwdata[0];
    if (w && ai >= 'h4000 && ai < 'h4000 + 8 * NH) begin
      h = (ai - 'h4000) / 8;
      if ((ai % 8) == 4) m_cmp[h][63:32] = pwdata;
      else               m_cmp[h][31:0]  = pwdata;
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < NH; k++) m_mtip[i][k] = (m_now(i) >= m_cmp[k]);
  endtask

  // driver tasks: entered and left at a falling edge
  task automatic tick_cycle();
    @(posedge clk_free);
    model_edge();
    @(negedge clk_free);
  endtask

  task automatic idle(int n);
    repeat (n) tick_cycle();
  endtask

  task automatic apb_write(logic [15:0] a, logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick_cycle();
    penable = 1'b1;
    tick_cycle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a,
                          output logic [31:0] rd0, output logic [31:0] rd1,
                          output logic err0, output logic err1,
                          output logic [31:0] exp0, output logic [31:0] exp1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick_cycle();
    penable = 1'b1;
    #1;
    rd0 = prdata0; rd1 = prdata1; err0 = pslverr0; err1 = pslverr1;
    exp0 = m_read(0, a); exp1 = m_read(1, a);
    tick_cycle();
    psel = 1'b0; penable = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    logic [63:0] e;
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    model_reset();
    #12;
    checks++;
    if (mtime0 !== 64'h0 || mtime1 !== 64'h0) begin
      errors++; $display("FAIL reset_mtime got %h/%h exp 0", mtime0, mtime1);
    end
    checks++;
    if (mtip0 !== '0 || mtip1 !== '0 || msip0 !== '0 || msip1 !== '0) begin
      errors++; $display("FAIL reset_irq mtip %b/%b msip %b/%b exp 0", mtip0, mtip1, msip0, msip1);
    end
    checks++;
    if (prdata0 !== 32'h0 || pslverr0 !== 1'b0 || pready0 !== 1'b1 || pready1 !== 1'b1) begin
      errors++; $display("FAIL reset_apb prdata %h pslverr %b pready %b exp 0/0/1", prdata0, pslverr0, pready0);
    end
    @(negedge clk_free);
    rstn = 1'b1;
    for (int k = 1; k <= 3; k++) exp_q.push_back(64'(k));
    for (int k = 1; k <= 3; k++) begin
      tick_cycle();
      e = exp_q.pop_front();
      checks++;
      if (mtime0 !== e) begin
        errors++; $display("FAIL reset_count step %0d got %h exp %h", k, mtime0, e);
      end
      checks++;
      if (mtime1 !== 64'h0 || mtip0 !== '0) begin
        errors++; $display("FAIL reset_div4_hold step %0d got %h mtip %b exp 0", k, mtime1, mtip0);
      end
    end
  endtask

  task automatic test_prescaler();
    logic [31:0] r0, r1, x0, x1;
    logic e0, e1;
    apb_write(16'hBFF8, 32'h10);
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (mtime1 !== ((k == 4) ? 64'h11 : 64'h10)) begin
        errors++; $display("FAIL prescale_div4 sample %0d got %h exp %h", k, mtime1, (k == 4) ? 64'h11 : 64'h10);
      end
      checks++;
      if (mtime0 !== 64'h10 + 64'(k)) begin
        errors++; $display("FAIL prescale_div1 sample %0d got %h exp %h", k, mtime0, 64'h10 + 64'(k));
      end
      if (k < 4) tick_cycle();
    end
    apb_read(16'hBFF8, r0, r1, e0, e1, x0, x1);
    checks++;
    if (r0 !== x0 || r1 !== x1 || e0 !== 1'b0) begin
      errors++; $display("FAIL prescale_readback got %h/%h err %b exp %h/%h", r0, r1, e0, x0, x1);
    end
  endtask

  task automatic test_mtip_compare();
    apb_write(16'hBFFC, 32'h0);
    apb_write(16'hBFF8, 32'h0);
    apb_write(16'h4004, 32'h0);
    apb_write(16'h4000, 32'h20);
    apb_write(16'hBFF8, 32'h1E);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mtime0 !== 64'h1E + 64'(k) || mtip0[0] !== (k >= 2)) begin
        errors++; $display("FAIL mtip_rise step %0d mtime %h mtip %b exp %h/%b", k, mtime0, mtip0[0], 64'h1E + 64'(k), k >= 2);
      end
      checks++;
      if (mtip1 !== m_mtip[1] || mtime1 !== m_now(1)) begin
        errors++; $display("FAIL mtip_rise_div4 step %0d mtime %h mtip %b exp %h/%b", k, mtime1, mtip1, m_now(1), m_mtip[1]);
      end
      if (k < 3) tick_cycle();
    end
    apb_write(16'h4004, 32'hFFFF_FFFF);
    checks++;
    if (mtip0[0] !== 1'b0 || mtip1 !== m_mtip[1]) begin
      errors++; $display("FAIL mtip_fall got %b/%b exp 0/%b", mtip0[0], mtip1, m_mtip[1]);
    end
  endtask

  task automatic test_wrap();
    apb_write(16'h4000, 32'hFFFF_FFFF);
    apb_write(16'hBFFC, 32'hFFFF_FFFF);
    apb_write(16'hBFF8, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mtime0 !== (64'hFFFF_FFFF_FFFF_FFFE + 64'(k)) || mtip0[0] !== (k == 1)) begin
        errors++; $display("FAIL wrap step %0d mtime %h mtip %b exp %h/%b", k, mtime0, mtip0[0], 64'hFFFF_FFFF_FFFF_FFFE + 64'(k), k == 1);
      end
      checks++;
      if (mtime1 !== m_now(1) || mtip1 !== m_mtip[1]) begin
        errors++; $display("FAIL wrap_div4 step %0d mtime %h mtip %b exp %h/%b", k, mtime1, mtip1, m_now(1), m_mtip[1]);
      end
      if (k < 2) tick_cycle();
    end
  endtask

  task automatic test_msip();
    logic [31:0] r0, r1, x0, x1;
    logic e0, e1;
    apb_write(16'h0000, 32'hFFFF_FFFF);
    checks++;
    if (msip0 !== 2'b01 || msip1 !== 2'b01) begin
      errors++; $display("FAIL msip_set got %b/%b exp 01", msip0, msip1);
    end
    apb_read(16'h0000, r0, r1, e0, e1, x0, x1);
    checks++;
    if (r0 !== 32'h1 || r1 !== 32'h1 || e0 !== 1'b0) begin
      errors++; $display("FAIL msip_read got %h/%h err %b exp 1/1/0", r0, r1, e0);
    end
    apb_write(16'h0004, 32'h1);
    apb_write(16'h0000, 32'h0);
    checks++;
    if (msip0 !== 2'b10 || msip1 !== 2'b10) begin
      errors++; $display("FAIL msip_clear got %b/%b exp 10", msip0, msip1);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r0, r1, x0, x1;
    logic e0, e1;
    logic [15:0] bad [3];
    bad[0] = 16'h1000; bad[1] = 16'h4002; bad[2] = 16'hBFF9;
    for (int k = 0; k < 3; k++) begin
      apb_read(bad[k], r0, r1, e0, e1, x0, x1);
      checks++;
      if (e0 !== 1'b1 || e1 !== 1'b1 || r0 !== 32'h0 || r1 !== 32'h0) begin
        errors++; $display("FAIL err_read addr %h err %b/%b data %h/%h exp 1/1/0/0", bad[k], e0, e1, r0, r1);
      end
    end
    apb_write(16'h0008, 32'h1);
    apb_write(16'h4010, 32'h0);
    apb_write(16'h4014, 32'h0);
    apb_write(16'hBFF9, 32'h0);
    apb_write(16'hBFFA, 32'h0);
    checks++;
    if (msip0 !== m_msip || mtime0 !== m_now(0) || mtime1 !== m_now(1) || mtip0 !== m_mtip[0]) begin
      errors++; $display("FAIL err_write_state msip %b mtime %h/%h mtip %b exp %b %h/%h %b",
                         msip0, mtime0, mtime1, mtip0, m_msip, m_now(0), m_now(1), m_mtip[0]);
    end
    for (int a = 'h4000; a < 'h4010; a += 4) begin
      apb_read(16'(a), r0, r1, e0, e1, x0, x1);
      checks++;
      if (r0 !== x0 || e0 !== 1'b0) begin
        errors++; $display("FAIL err_cmp_intact addr %h got %h exp %h", a, r0, x0);
      end
    end
  endtask

  task automatic test_async_reset();
    apb_write(16'h0000, 32'h1);
    idle(3);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    checks++;
    if (mtime0 !== 64'h0 || mtime1 !== 64'h0 || msip0 !== '0 || mtip0 !== '0 || mtip1 !== '0) begin
      errors++; $display("FAIL async_reset mtime %h/%h msip %b mtip %b/%b exp 0", mtime0, mtime1, msip0, mtip0, mtip1);
    end
    @(negedge clk_free);
    rstn = 1'b1;
    tick_cycle();
    checks++;
    if (mtime0 !== 64'h1 || mtime1 !== 64'h0) begin
      errors++; $display("FAIL async_resume got %h/%h exp 1/0", mtime0, mtime1);
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [12];
    logic [31:0] hi_vals [3];
    logic [31:0] r0, r1, x0, x1, d;
    logic e0, e1;
    logic [15:0] a;
    int op;
    pool[0] = 16'h0000; pool[1] = 16'h0004; pool[2] = 16'h4000; pool[3] = 16'h4004;
    pool[4] = 16'h4008; pool[5] = 16'h400C; pool[6] = 16'hBFF8; pool[7] = 16'hBFFC;
    pool[8] = 16'h0008; pool[9] = 16'h4010; pool[10] = 16'h4001; pool[11] = 16'h2000;
    hi_vals[0] = 32'h0; hi_vals[1] = 32'h1; hi_vals[2] = 32'hFFFF_FFFF;
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      a  = pool[$urandom_range(0, 11)];
      if (a == 16'h4004 || a == 16'h400C || a == 16'hBFFC) d = hi_vals[$urandom_range(0, 2)];
      else if ($urandom_range(0, 1) == 1) d = $urandom_range(0, 64);
      else d = $urandom;
      if (op < 5) begin
        apb_write(a, d);
      end else if (op < 8) begin
        apb_read(a, r0, r1, e0, e1, x0, x1);
        exp_q.push_back({x1, x0});
        checks++;
        if ({r1, r0} !== exp_q.pop_front() || e0 !== !addr_valid(a) || e1 !== !addr_valid(a)) begin
          errors++; $display("FAIL rand_read op %0d addr %h got %h/%h err %b exp %h/%h err %b",
                             n, a, r0, r1, e0, x0, x1, !addr_valid(a));
        end
      end else begin
        idle(int'($urandom_range(1, 6)));
      end
      checks++;
      if (mtime0 !== m_now(0) || mtime1 !== m_now(1)) begin
        errors++; $display("FAIL rand_mtime op %0d got %h/%h exp %h/%h", n, mtime0, mtime1, m_now(0), m_now(1));
      end
      checks++;
      if (mtip0 !== m_mtip[0] || mtip1 !== m_mtip[1]) begin
        errors++; $display("FAIL rand_mtip op %0d got %b/%b exp %b/%b", n, mtip0, mtip1, m_mtip[0], m_mtip[1]);
      end
      checks++;
      if (msip0 !== m_msip || msip1 !== m_msip) begin
        errors++; $display("FAIL rand_msip op %0d got %b/%b exp %b", n, msip0, msip1, m_msip);
      end
    end
  endtask

  initial begin
    m_td[0] = 1;
    m_td[1] = 4;
    test_reset();
    test_prescaler();
    test_mtip_compare();
    test_wrap();
    test_msip();
    test_errors();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
